// File: rtl/meteor_sprite_scheduler.sv
// meteor_sprite_scheduler
//   Shares one sprite ROM/palette between NUM_SLOTS meteor instances. Each
//   pixel it selects the lowest-numbered slot covering the beam, drives the
//   shared ROM address, and carries hit/slot through the ROM's one-cycle read
//   latency. Slot positions are written into shadow registers at any time and
//   copied to the active set only at the frame boundary (DrawX==0, DrawY==480).
//
// Ports
//   vga_clk, reset_n          pixel clock, async active-low reset
//   DrawX, DrawY, blank       beam position, blank=1 in active video
//   wr_en/wr_slot/wr_x/wr_y/wr_on   shadow slot write
//   commit_req                request shadow->active copy at next boundary
//   commit_ack                one-cycle pulse, coincides with frame_tick
//   frame_tick                one-cycle pulse after the boundary cycle
//   rom_address               registered shared ROM address
//   rom_q                     ROM palette index, valid one cycle later
//   sprite_on, sprite_slot    opaque pixel flag / winning slot, aligned to rom_q
module meteor_sprite_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int SPR_W           = 21,
  parameter int SPR_H           = 24,
  parameter int SCALE_SHIFT     = 2,
  parameter int ADDR_W          = 10,
  parameter int IDX_W           = 5,
  parameter int TRANSPARENT_IDX = 0,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_slot,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic              wr_on,
  input  logic              commit_req,
  output logic              commit_ack,
  output logic              frame_tick,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              sprite_on,
  output logic [SW-1:0]     sprite_slot
);

  localparam logic [10:0]      FOOT_W = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0]      FOOT_H = 11'(SPR_H << SCALE_SHIFT);
  localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSPARENT_IDX);

  logic [9:0] sh_x_q  [NUM_SLOTS];
  logic [9:0] sh_y_q  [NUM_SLOTS];
  logic       sh_on_q [NUM_SLOTS];
  logic [9:0] act_x_q [NUM_SLOTS];
  logic [9:0] act_y_q [NUM_SLOTS];
  logic       act_on_q[NUM_SLOTS];

  logic pend_q, pend_d;
  logic boundary, do_commit;

  logic [10:0]          dx [NUM_SLOTS];
  logic [10:0]          dy [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit_vec;
  logic                 hit_d;
  logic [SW-1:0]        slot_d;
  logic [10:0]          dx_sel, dy_sel;
  logic [ADDR_W-1:0]    addr_d;

  logic              tick_q, ack_q;
  logic [ADDR_W-1:0] rom_address_q;
  logic              hit_p1_q, hit_p2_q;
  logic [SW-1:0]     slot_p1_q, slot_p2_q;

  assign boundary  = (DrawX == 10'd0) && (DrawY == 10'd480);
  // A request arriving in the boundary cycle itself still commits this frame.
  assign do_commit = boundary && (pend_q || commit_req);

  always_comb begin
    pend_d = pend_q;
    if (do_commit)       pend_d = 1'b0;
    else if (commit_req) pend_d = 1'b1;
  end

  // Differences are taken one bit wider than the beam so nothing wraps; the
  // >= terms make the unsigned subtraction meaningful.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dx[i] = {1'b0, DrawX} - {1'b0, act_x_q[i]};
      dy[i] = {1'b0, DrawY} - {1'b0, act_y_q[i]};
      hit_vec[i] = act_on_q[i] && blank &&
                   (DrawX >= act_x_q[i]) && (DrawY >= act_y_q[i]) &&
                   (dx[i] < FOOT_W) && (dy[i] < FOOT_H);
    end
  end

  // Scan from the top so the lowest hitting slot is the last one written.
  always_comb begin
    hit_d  = 1'b0;
    slot_d = '0;
    dx_sel = '0;
    dy_sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_d  = 1'b1;
        slot_d = SW'(i);
        dx_sel = dx[i];
        dy_sel = dy[i];
      end
    end
    addr_d = '0;
    if (hit_d)
      addr_d = ADDR_W'(int'(dy_sel >> SCALE_SHIFT) * SPR_W + int'(dx_sel >> SCALE_SHIFT));
  end

  // Shadow/active slot storage; the copy reads the pre-write shadow.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_x_q[i]   <= '0;
        sh_y_q[i]   <= '0;
        sh_on_q[i]  <= 1'b0;
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
        act_on_q[i] <= 1'b0;
      end
    end else begin
      if (do_commit) begin
        act_x_q  <= sh_x_q;
        act_y_q  <= sh_y_q;
        act_on_q <= sh_on_q;
      end
      if (wr_en) begin
        sh_x_q[wr_slot]  <= wr_x;
        sh_y_q[wr_slot]  <= wr_y;
        sh_on_q[wr_slot] <= wr_on;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q        <= 1'b0;
      tick_q        <= 1'b0;
      ack_q         <= 1'b0;
      rom_address_q <= '0;
      hit_p1_q      <= 1'b0;
      slot_p1_q     <= '0;
      hit_p2_q      <= 1'b0;
      slot_p2_q     <= '0;
    end else begin
      pend_q        <= pend_d;
      tick_q        <= boundary;
      ack_q         <= do_commit;
      // ---- stage 1: address and hit registered alongside ROM request ----
      rom_address_q <= addr_d;
      hit_p1_q      <= hit_d;
      slot_p1_q     <= slot_d;
      // ---- stage 2: aligned with rom_q returned by the ROM ----
      hit_p2_q      <= hit_p1_q;
      slot_p2_q     <= slot_p1_q;
    end
  end

  assign frame_tick  = tick_q;
  assign commit_ack  = ack_q;
  assign rom_address = rom_address_q;
  assign sprite_on   = hit_p2_q && (rom_q != TRANSP);
  assign sprite_slot = hit_p2_q ? slot_p2_q : '0;

endmodule
